// File: rtl/systolic_array.sv
// systolic_array: 4x4 weight-stationary systolic array for fixed-point
// matrix products in Q(WIDTH-FRAC_BIT).FRAC_BIT format. Each input row of A
// produces one output row of A*B, with a fixed latency of 8 enabled cycles
// and a throughput of one row per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         clock enable for every register
//   clr        synchronous clear of all state; takes priority over en and in_valid
//   a0..a3     one row of A (element k on ak), qualified by in_valid
//   in_valid   row valid; also loads b00..b33 into the weight registers
//   b00..b33   weight matrix B, bkj = row k, column j
//   y0..y3     one row of A*B, yj = column j (registered)
//   out_valid  qualifies y0..y3 (registered)
//
// Build option: define SYSTOLIC_ARRAY_SAT_EN to saturate each output word
// to the WIDTH-bit signed range; by default the low WIDTH bits are kept.
module systolic_array #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC_BIT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] b00,
    input  logic [WIDTH-1:0] b01,
    input  logic [WIDTH-1:0] b02,
    input  logic [WIDTH-1:0] b03,
    input  logic [WIDTH-1:0] b10,
    input  logic [WIDTH-1:0] b11,
    input  logic [WIDTH-1:0] b12,
    input  logic [WIDTH-1:0] b13,
    input  logic [WIDTH-1:0] b20,
    input  logic [WIDTH-1:0] b21,
    input  logic [WIDTH-1:0] b22,
    input  logic [WIDTH-1:0] b23,
    input  logic [WIDTH-1:0] b30,
    input  logic [WIDTH-1:0] b31,
    input  logic [WIDTH-1:0] b32,
    input  logic [WIDTH-1:0] b33,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             out_valid
);

    localparam int unsigned N     = 4;
    localparam int unsigned ACC_W = 2 * WIDTH + 2;
    localparam int unsigned LAT   = 8;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef logic signed [ACC_W-1:0] acc_t;

`ifdef SYSTOLIC_ARRAY_SAT_EN
    localparam acc_t SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    // Full-precision multiply of two signed words into the accumulator width.
    function automatic acc_t mac_prod(input word_t a, input word_t w);
        return ACC_W'(a) * ACC_W'(w);
    endfunction

    // Drop the fraction bits (floor) and fit the result into one output word.
    function automatic word_t scale(input acc_t s);
`ifdef SYSTOLIC_ARRAY_SAT_EN
        acc_t sh;
        sh = s >>> FRAC_BIT;
        if (sh > SAT_MAX) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sh < SAT_MIN) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return WIDTH'(sh);
        end
`else
        return WIDTH'(s >>> FRAC_BIT);
`endif
    endfunction

    // Port bundling into arrays.
    word_t a_in [N];
    word_t b_in [N][N];

    assign a_in[0] = a0;
    assign a_in[1] = a1;
    assign a_in[2] = a2;
    assign a_in[3] = a3;

    assign b_in[0][0] = b00;
    assign b_in[0][1] = b01;
    assign b_in[0][2] = b02;
    assign b_in[0][3] = b03;
    assign b_in[1][0] = b10;
    assign b_in[1][1] = b11;
    assign b_in[1][2] = b12;
    assign b_in[1][3] = b13;
    assign b_in[2][0] = b20;
    assign b_in[2][1] = b21;
    assign b_in[2][2] = b22;
    assign b_in[2][3] = b23;
    assign b_in[3][0] = b30;
    assign b_in[3][1] = b31;
    assign b_in[3][2] = b32;
    assign b_in[3][3] = b33;

    // State: input sample, input skew, weights, PE pipeline, de-skew, outputs.
    word_t            row_q [N];
    word_t            row_d [N];
    word_t            sk1_q, sk1_d;
    word_t            sk2_q [2];
    word_t            sk2_d [2];
    word_t            sk3_q [3];
    word_t            sk3_d [3];
    word_t            w_q   [N][N];
    word_t            w_d   [N][N];
    word_t            pa_q  [N][N-1];
    word_t            pa_d  [N][N-1];
    acc_t             ps_q  [N][N];
    acc_t             ps_d  [N][N];
    acc_t             dk0_q [3];
    acc_t             dk0_d [3];
    acc_t             dk1_q [2];
    acc_t             dk1_d [2];
    acc_t             dk2_q, dk2_d;
    logic [LAT-1:0]   vld_q, vld_d;
    word_t            y_q   [N];
    word_t            y_d   [N];
    logic             ov_q, ov_d;

    // Datapath taps: operand seen by each PE and de-skewed column sums.
    word_t skew_out [N];
    word_t pe_a     [N][N];
    acc_t  col_sum  [N];

    // Row k enters the array k cycles late; a moves right one PE per cycle.
    always_comb begin
        skew_out[0] = row_q[0];
        skew_out[1] = sk1_q;
        skew_out[2] = sk2_q[1];
        skew_out[3] = sk3_q[2];
        for (int k = 0; k < N; k++) begin
            pe_a[k][0] = skew_out[k];
            for (int j = 1; j < N; j++) begin
                pe_a[k][j] = pa_q[k][j-1];
            end
        end
        // Column j leaves the bottom row at offset j; delay it by 3-j to realign.
        col_sum[0] = dk0_q[2];
        col_sum[1] = dk1_q[1];
        col_sum[2] = dk2_q;
        col_sum[3] = ps_q[N-1][N-1];
    end

    // Next-state for every register; clr forces everything to zero.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            row_d[k] = in_valid ? a_in[k] : '0;
        end
        sk1_d    = row_q[1];
        sk2_d[0] = row_q[2];
        sk2_d[1] = sk2_q[0];
        sk3_d[0] = row_q[3];
        sk3_d[1] = sk3_q[0];
        sk3_d[2] = sk3_q[1];

        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                w_d[k][j] = in_valid ? b_in[k][j] : w_q[k][j];
            end
            for (int j = 0; j < N - 1; j++) begin
                pa_d[k][j] = pe_a[k][j];
            end
        end

        // Partial sums flow down each column.
        for (int j = 0; j < N; j++) begin
            ps_d[0][j] = mac_prod(pe_a[0][j], w_q[0][j]);
            for (int k = 1; k < N; k++) begin
                ps_d[k][j] = ps_q[k-1][j] + mac_prod(pe_a[k][j], w_q[k][j]);
            end
        end

        dk0_d[0] = ps_q[N-1][0];
        dk0_d[1] = dk0_q[0];
        dk0_d[2] = dk0_q[1];
        dk1_d[0] = ps_q[N-1][1];
        dk1_d[1] = dk1_q[0];
        dk2_d    = ps_q[N-1][2];

        vld_d = {vld_q[LAT-2:0], in_valid};
        ov_d  = vld_q[LAT-1];
        for (int j = 0; j < N; j++) begin
            y_d[j] = vld_q[LAT-1] ? scale(col_sum[j]) : '0;
        end

        if (clr) begin
            row_d = '{default: '0};
            sk1_d = '0;
            sk2_d = '{default: '0};
            sk3_d = '{default: '0};
            w_d   = '{default: '0};
            pa_d  = '{default: '0};
            ps_d  = '{default: '0};
            dk0_d = '{default: '0};
            dk1_d = '{default: '0};
            dk2_d = '0;
            vld_d = '0;
            y_d   = '{default: '0};
            ov_d  = 1'b0;
        end
    end

    // State registers; clr acts even when en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '{default: '0};
            sk1_q <= '0;
            sk2_q <= '{default: '0};
            sk3_q <= '{default: '0};
            w_q   <= '{default: '0};
            pa_q  <= '{default: '0};
            ps_q  <= '{default: '0};
            dk0_q <= '{default: '0};
            dk1_q <= '{default: '0};
            dk2_q <= '0;
            vld_q <= '0;
            y_q   <= '{default: '0};
            ov_q  <= 1'b0;
        end else if (en || clr) begin
            row_q <= row_d;
            sk1_q <= sk1_d;
            sk2_q <= sk2_d;
            sk3_q <= sk3_d;
            w_q   <= w_d;
            pa_q  <= pa_d;
            ps_q  <= ps_d;
            dk0_q <= dk0_d;
            dk1_q <= dk1_d;
            dk2_q <= dk2_d;
            vld_q <= vld_d;
            y_q   <= y_d;
            ov_q  <= ov_d;
        end
    end

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign out_valid = ov_q;

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: table of rows with hand-computed results,
// plus stall, clear and reset sequences in the middle of a burst.
module tb_systolic_array;

    typedef logic signed [15:0] word_t;

    typedef struct packed {
        logic [1:0]       bsel;
        logic [3:0][15:0] a;
        logic [3:0][15:0] y;
    } vec_t;

    logic  clk;
    logic  rst_n;
    logic  en;
    logic  clr;
    logic  in_valid;
    word_t am [4];
    word_t bm [4][4];
    word_t yw [4];
    logic  ov;

    word_t bmat [3][4][4];
    vec_t  vt   [6];

    int n_checks = 0;
    int n_fail   = 0;

    systolic_array #(.WIDTH(16), .FRAC_BIT(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .a0(am[0]), .a1(am[1]), .a2(am[2]), .a3(am[3]),
        .in_valid(in_valid),
        .b00(bm[0][0]), .b01(bm[0][1]), .b02(bm[0][2]), .b03(bm[0][3]),
        .b10(bm[1][0]), .b11(bm[1][1]), .b12(bm[1][2]), .b13(bm[1][3]),
        .b20(bm[2][0]), .b21(bm[2][1]), .b22(bm[2][2]), .b23(bm[2][3]),
        .b30(bm[3][0]), .b31(bm[3][1]), .b32(bm[3][2]), .b33(bm[3][3]),
        .y0(yw[0]), .y1(yw[1]), .y2(yw[2]), .y3(yw[3]),
        .out_valid(ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input int bs, input int p0, input int p1, input int p2,
                                input int p3, input int q0, input int q1, input int q2,
                                input int q3);
        vec_t v;
        v.bsel = 2'(bs);
        v.a[0] = 16'(p0); v.a[1] = 16'(p1); v.a[2] = 16'(p2); v.a[3] = 16'(p3);
        v.y[0] = 16'(q0); v.y[1] = 16'(q1); v.y[2] = 16'(q2); v.y[3] = 16'(q3);
        return v;
    endfunction

    task automatic set_brow(input int s, input int k, input int c0, input int c1,
                            input int c2, input int c3);
        bmat[s][k][0] = 16'(c0);
        bmat[s][k][1] = 16'(c1);
        bmat[s][k][2] = 16'(c2);
        bmat[s][k][3] = 16'(c3);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input vec_t v, input string tag);
        chk({tag, " out_valid"}, int'(ov), 1);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s y%0d", tag, j), int'(yw[j]), int'($signed(v.y[j])));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " out_valid"}, int'(ov), 0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s y%0d", tag, j), int'(yw[j]), 0);
        end
    endtask

    task automatic drive_row(input vec_t v);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            am[k] = $signed(v.a[k]);
            for (int j = 0; j < 4; j++) bm[k][j] = bmat[v.bsel][k][j];
        end
    endtask

    // Nonzero garbage while in_valid is low: must neither reach the sums nor the weights.
    task automatic drive_idle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            am[k] = 16'sh1357 + 16'(k);
            for (int j = 0; j < 4; j++) bm[k][j] = 16'sh0F0F;
        end
    endtask

    // Back-to-back rows, then drain; each row expected exactly 8 edges later.
    task automatic run_burst(input int first, input int n, input string tag);
        for (int c = 0; c < n + 9; c++) begin
            @(negedge clk);
            if (c < n) drive_row(vt[first + c]);
            else drive_idle();
            @(posedge clk);
            #1;
            if (c >= 8 && c < n + 8) check_row(vt[first + c - 8], $sformatf("%s row%0d", tag, c - 8));
            else check_idle($sformatf("%s cyc%0d", tag, c));
        end
    endtask

    // Feed rows 0..2 of the first burst and run until row 0 is on the outputs.
    task automatic start_burst3(input string tag);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 3) drive_row(vt[c]);
            else drive_idle();
            @(posedge clk);
            #1;
            if (c == 8) check_row(vt[0], {tag, " row0"});
        end
    endtask

    initial begin
        set_brow(0, 0, 8192, 8192, 5120, 5120);
        set_brow(0, 1, 8192, 5120, 8192, 5120);
        set_brow(0, 2, 1024, 1024, 1024, 1024);
        set_brow(0, 3, 0, 0, 0, 0);
        set_brow(1, 0, 906, 115, 115, 2);
        set_brow(1, 1, 1024, 1024, 1024, 1024);
        set_brow(1, 2, 1024, 1024, 1024, 1023);
        set_brow(1, 3, 1024, 1024, 1024, 1024);
        for (int k = 0; k < 4; k++) set_brow(2, k, 32767, 32767, 32767, 32767);

        vt[0] = mk(0, 1403, 1403, -20357, 0, 2091, -2118, -2118, -6327);
        vt[1] = mk(0, 788, 993, -922, 0, 13326, 10347, 10962, 7983);
        vt[2] = mk(0, 1075, 655, -911, 0, 12929, 10964, 9704, 7739);
        vt[3] = mk(1, 7281, -1341, 82, -2652, 2530, -3094, -3094, -3897);
        vt[4] = mk(1, -7270, 1669, 2017, 205, -2542, 3074, 3074, 3874);
`ifdef SYSTOLIC_ARRAY_SAT_EN
        vt[5] = mk(2, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
`else
        vt[5] = mk(2, 32767, 32767, 32767, 32767, -256, -256, -256, -256);
`endif

        // Reset state.
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        drive_idle();
        #23;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("after reset");

        // Table-driven bursts: 3x3 case, 2x4 case, overflow.
        run_burst(0, 3, "b3x3");
        run_burst(3, 2, "b2x4");
        run_burst(5, 1, "ovf");

        // en low for 3 cycles with rows in flight: outputs freeze, rest arrive 3 later.
        start_burst3("stall");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            en = 1'b0;
            drive_idle();
            @(posedge clk);
            #1;
            check_row(vt[0], $sformatf("stall frozen%0d", c));
        end
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c < 2) check_row(vt[c + 1], $sformatf("stall row%0d", c + 1));
            else check_idle("stall drained");
        end

        // clr with en low mid-burst: zero next edge, no stale rows after.
        start_burst3("clr");
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        check_idle("clr edge");
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("clr after%0d", c));
        end

        // Async reset mid-burst: zero at once, next row exactly 8 edges after release.
        start_burst3("rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("rst immediate");
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(3, 1, "post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
